// File: rtl/imem_loader.sv
// imem_loader: encodes symbolic MIPS instructions into machine words and
// writes them sequentially into instruction memory. It holds the core
// disabled until the program is loaded, then releases it.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (running XOR of written words).
module imem_loader #(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  input  logic              restart,
  output logic              imem_we,
  output logic [AWIDTH-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_enable,
  output logic [AWIDTH:0]   words_loaded,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam int unsigned CW = AWIDTH + 1;
  localparam logic [AWIDTH-1:0] ADDR_BASE = AWIDTH'(BASE);
  localparam logic [AWIDTH-1:0] ADDR_MAX  = '1;

  typedef enum logic [1:0] {S_LOAD, S_FLUSH, S_RUN, S_ERR} state_t;
  typedef enum logic [2:0] {F_R, F_SH, F_JR, F_I, F_LUI, F_J} fmt_t;

  state_t            r_state;
  logic [AWIDTH-1:0] r_addr;
  fmt_t              w_fmt;
  logic [5:0]        w_code;
  logic              w_legal;
  logic [31:0]       w_word;
  logic              w_accept;
  logic              w_write;
  logic              w_restart;

  assign w_accept  = in_valid & in_ready;
  assign w_write   = w_accept & w_legal;
  assign w_restart = restart & ((r_state == S_RUN) | (r_state == S_ERR));

  // Mnemonic decode: instruction format and op/func code
  always_comb begin
    w_legal = 1'b1;
    w_fmt   = F_R;
    w_code  = 6'b000000;
    case (in_mnem)
      5'd0:  w_code = 6'b100000;
      5'd1:  w_code = 6'b100001;
      5'd2:  w_code = 6'b100010;
      5'd3:  w_code = 6'b100100;
      5'd4:  w_code = 6'b100101;
      5'd5:  w_code = 6'b100110;
      5'd6:  w_code = 6'b100111;
      5'd7:  w_code = 6'b101010;
      5'd8:  w_code = 6'b101011;
      5'd9:  begin w_fmt = F_SH;  w_code = 6'b000000; end
      5'd10: w_code = 6'b000100;
      5'd11: begin w_fmt = F_SH;  w_code = 6'b000010; end
      5'd12: begin w_fmt = F_SH;  w_code = 6'b000011; end
      5'd13: begin w_fmt = F_JR;  w_code = 6'b001000; end
      5'd14: begin w_fmt = F_I;   w_code = 6'b100011; end
      5'd15: begin w_fmt = F_I;   w_code = 6'b101011; end
      5'd16: begin w_fmt = F_I;   w_code = 6'b001000; end
      5'd17: begin w_fmt = F_I;   w_code = 6'b001001; end
      5'd18: begin w_fmt = F_I;   w_code = 6'b001010; end
      5'd19: begin w_fmt = F_I;   w_code = 6'b001011; end
      5'd20: begin w_fmt = F_I;   w_code = 6'b001101; end
      5'd21: begin w_fmt = F_LUI; w_code = 6'b001111; end
      5'd22: begin w_fmt = F_I;   w_code = 6'b001100; end
      5'd23: begin w_fmt = F_I;   w_code = 6'b001110; end
      5'd24: begin w_fmt = F_I;   w_code = 6'b000100; end
      5'd25: begin w_fmt = F_I;   w_code = 6'b000101; end
      5'd26: begin w_fmt = F_J;   w_code = 6'b000010; end
      5'd27: begin w_fmt = F_J;   w_code = 6'b000011; end
      default: w_legal = 1'b0;
    endcase
  end

  // Field packing per format; unused input fields are dropped here
  always_comb begin
    w_word = '0;
    case (w_fmt)
      F_R:     w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, w_code};
      F_SH:    w_word = {6'b000000, 5'b00000, in_rt, in_rd, in_shamt, w_code};
      F_JR:    w_word = {6'b000000, in_rs, 15'd0, w_code};
      F_I:     w_word = {w_code, in_rs, in_rt, in_imm};
      F_LUI:   w_word = {w_code, 5'b00000, in_rt, in_imm};
      F_J:     w_word = {w_code, in_target};
      default: w_word = '0;
    endcase
  end

  // Loader FSM with registered write port, handshake and core enable
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_addr       <= ADDR_BASE;
      in_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= ADDR_BASE;
      imem_wd      <= '0;
      cpu_enable   <= 1'b0;
      words_loaded <= '0;
      error        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            if (!w_legal) begin
              r_state  <= S_ERR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              imem_we      <= 1'b1;
              imem_addr    <= r_addr;
              imem_wd      <= w_word;
              words_loaded <= words_loaded + CW'(1);
              r_addr       <= r_addr + AWIDTH'(1);
              if (in_last) begin
                r_state  <= S_FLUSH;
                in_ready <= 1'b0;
              end else if (r_addr == ADDR_MAX) begin
                r_state  <= S_ERR;
                error    <= 1'b1;
                in_ready <= 1'b0;
              end
            end
          end
        end
        S_FLUSH: r_state <= S_RUN;
        S_RUN, S_ERR: begin
          // Enable trails FLUSH by a cycle so no write overlaps execution
          cpu_enable <= (r_state == S_RUN) & ~restart;
          if (restart) begin
            r_state      <= S_LOAD;
            r_addr       <= ADDR_BASE;
            in_ready     <= 1'b1;
            imem_addr    <= ADDR_BASE;
            words_loaded <= '0;
            error        <= 1'b0;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running XOR of every word written since reset or restart
  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_restart) begin
      r_checksum <= '0;
    end else if (w_write) begin
      r_checksum <= r_checksum ^ w_word;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed program scenarios plus a
// randomized program load checked against an encoding model.
module tb_imem_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_last, restart, v2;
  logic [4:0]  in_mnem, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, imem_we, cpu_enable, error;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wd, checksum;
  logic [10:0] words_loaded;

  logic        rdy2, we2, en2, err2;
  logic [1:0]  addr2;
  logic [31:0] wd2, cs2;
  logic [2:0]  wl2;

  int checks = 0;
  int errors = 0;

  imem_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wd(imem_wd), .cpu_enable(cpu_enable),
    .words_loaded(words_loaded), .error(error), .checksum(checksum)
  );

  imem_loader #(.AWIDTH(2), .BASE(0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .in_last(1'b0), .restart(1'b0), .imem_we(we2),
    .imem_addr(addr2), .imem_wd(wd2), .cpu_enable(en2),
    .words_loaded(wl2), .error(err2), .checksum(cs2)
  );

  // Encoding tables: R-type func by mnemonic 0..13, opcode by mnemonic 14..27
  localparam logic [5:0] RFUNC [14] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                        6'h2a, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h03, 6'h08};
  localparam logic [5:0] IOP   [14] = '{6'h23, 6'h2b, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0d,
                                        6'h0f, 6'h0c, 6'h0e, 6'h04, 6'h05, 6'h02, 6'h03};

  function automatic logic [31:0] ref_encode(input logic [4:0] m, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [15:0] imm, input logic [25:0] tgt);
    int k;
    logic [5:0] c;
    k = int'(m);
    if (k < 14) begin
      c = RFUNC[k];
      if (k == 9 || k == 11 || k == 12) return {11'd0, rt, rd, sh, c};
      if (k == 13) return {6'd0, rs, 15'd0, c};
      return {6'd0, rs, rt, rd, 5'd0, c};
    end
    c = IOP[k - 14];
    if (k >= 26) return {c, tgt};
    if (k == 21) return {c, 5'd0, rt, imm};
    return {c, rs, rt, imm};
  endfunction

  function automatic logic [31:0] cur_word();
    return ref_encode(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
      input logic [25:0] tgt, input logic last);
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
  endtask

  task automatic rand_instr(input logic last);
    set_instr(5'($urandom_range(0, 27)), 5'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 16'($urandom), 26'($urandom), last);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; v2 = 1'b0; restart = 1'b0;
    set_instr(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", imem_we); end
    checks++; if (imem_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
    checks++; if (imem_wd !== 32'd0) begin errors++; $display("FAIL reset_wd got %h want 0", imem_wd); end
    checks++; if (cpu_enable !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_en_err got %0b/%0b want 0/0", cpu_enable, error); end
    checks++; if (words_loaded !== 11'd0 || checksum !== 32'd0) begin errors++; $display("FAIL reset_cnt_cs got %0d/%h want 0/0", words_loaded, checksum); end
  endtask

  task automatic test_plan_program();
    logic [31:0] exp_cs;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_cs = 32'h21015025;
`else
    exp_cs = 32'd0;
`endif
    set_instr(5'd16, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1'b0);
    tick();
    checks++; if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wd !== 32'h20080005) begin errors++;
      $display("FAIL addi_write got we=%0b addr=%0d wd=%h want 1/0/20080005", imem_we, imem_addr, imem_wd); end
    set_instr(5'd0, 5'd8, 5'd9, 5'd10, 5'd0, 16'd0, 26'd0, 1'b1);
    tick();
    checks++; if (imem_we !== 1'b1 || imem_addr !== 10'd1 || imem_wd !== 32'h01095020) begin errors++;
      $display("FAIL add_write got we=%0b addr=%0d wd=%h want 1/1/01095020", imem_we, imem_addr, imem_wd); end
    checks++; if (words_loaded !== 11'd2 || in_ready !== 1'b0 || cpu_enable !== 1'b0) begin errors++;
      $display("FAIL last_edge got wl=%0d rdy=%0b en=%0b want 2/0/0", words_loaded, in_ready, cpu_enable); end
    in_valid = 1'b0; in_last = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++; if (imem_we !== 1'b0 || cpu_enable !== 1'b0) begin errors++;
      $display("FAIL flush_cycle got we=%0b en=%0b want 0/0", imem_we, cpu_enable); end
    tick();
    checks++; if (cpu_enable !== 1'b1 || words_loaded !== 11'd2) begin errors++;
      $display("FAIL run_enable got en=%0b wl=%0d want 1/2", cpu_enable, words_loaded); end
    checks++; if (checksum !== exp_cs) begin errors++; $display("FAIL plan_checksum got %h want %h", checksum, exp_cs); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++; if (in_ready !== 1'b1 || cpu_enable !== 1'b0 || imem_addr !== 10'd0 || words_loaded !== 11'd0 || checksum !== 32'd0) begin errors++;
      $display("FAIL run_restart got rdy=%0b en=%0b addr=%0d wl=%0d cs=%h want 1/0/0/0/0", in_ready, cpu_enable, imem_addr, words_loaded, checksum); end
  endtask

  task automatic test_shift_jump();
    logic [31:0] exp [3];
    exp[0] = 32'h00031100; exp[1] = 32'h08000010; exp[2] = 32'h0C000010;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_instr(5'd9, 5'd31, 5'd3, 5'd2, 5'd4, 16'($urandom), 26'($urandom), 1'b0);
        1: set_instr(5'd26, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'h10, 1'b0);
        default: set_instr(5'd27, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'h10, 1'b1);
      endcase
      tick();
      checks++; if (imem_we !== 1'b1 || imem_addr !== 10'(i) || imem_wd !== exp[i]) begin errors++;
        $display("FAIL shift_jump_%0d got we=%0b addr=%0d wd=%h want 1/%0d/%h", i, imem_we, imem_addr, imem_wd, i, exp[i]); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL shift_jump_run got %0b want 1", cpu_enable); end
    restart = 1'b1; tick(); restart = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      rand_instr(1'b0);
      w = cur_word();
      tick();
      checks++; if (imem_we !== 1'b1 || imem_addr !== 10'(i) || imem_wd !== w) begin errors++;
        $display("FAIL pre_illegal_%0d got we=%0b addr=%0d wd=%h want 1/%0d/%h", i, imem_we, imem_addr, imem_wd, i, w); end
    end
    set_instr(5'd29, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom), 1'b0);
    tick();
    checks++; if (imem_we !== 1'b0 || error !== 1'b1 || in_ready !== 1'b0 || words_loaded !== 11'd3) begin errors++;
      $display("FAIL illegal got we=%0b err=%0b rdy=%0b wl=%0d want 0/1/0/3", imem_we, error, in_ready, words_loaded); end
    set_instr(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
    tick();
    checks++; if (imem_we !== 1'b0 || words_loaded !== 11'd3 || error !== 1'b1) begin errors++;
      $display("FAIL err_ignores_valid got we=%0b wl=%0d err=%0b want 0/3/1", imem_we, words_loaded, error); end
    in_valid = 1'b0;
    restart = 1'b1; tick(); restart = 1'b0;
    checks++; if (error !== 1'b0 || imem_addr !== 10'd0 || in_ready !== 1'b1 || words_loaded !== 11'd0) begin errors++;
      $display("FAIL err_restart got err=%0b addr=%0d rdy=%0b wl=%0d want 0/0/1/0", error, imem_addr, in_ready, words_loaded); end
    restart = 1'b1; tick(); restart = 1'b0;
    checks++; if (in_ready !== 1'b1 || error !== 1'b0) begin errors++;
      $display("FAIL load_restart_ignored got rdy=%0b err=%0b want 1/0", in_ready, error); end
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic [31:0] w, cs;
    int k;
    cs = 32'd0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rand_gap_%0d got we=%0b want 0", i, imem_we); end
      end
      rand_instr(i == N - 1);
      w = cur_word();
      cs = cs ^ w;
      tick();
      checks++; if (imem_we !== 1'b1 || imem_addr !== 10'(i) || imem_wd !== w || words_loaded !== 11'(i + 1)) begin errors++;
        $display("FAIL rand_write_%0d got we=%0b addr=%0d wd=%h wl=%0d want 1/%0d/%h/%0d", i, imem_we, imem_addr, imem_wd, words_loaded, i, w, i + 1); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    k = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (cpu_enable === 1'b1) begin k = c; break; end
    end
    checks++; if (k != 2) begin errors++; $display("FAIL rand_enable_delay got %0d edges want 2", k); end
`ifndef IMEM_LOADER_CHECKSUM_EN
    cs = 32'd0;
`endif
    checks++; if (checksum !== cs) begin errors++; $display("FAIL rand_checksum got %h want %h", checksum, cs); end
    restart = 1'b1; tick(); restart = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    rand_instr(1'b0);
    tick();
    in_valid = 1'b0;
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL pending_write got we=%0b want 1", imem_we); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_wd !== 32'd0 || in_ready !== 1'b1 ||
                  words_loaded !== 11'd0 || error !== 1'b0 || cpu_enable !== 1'b0 || checksum !== 32'd0) begin errors++;
      $display("FAIL reset_mid_write got we=%0b addr=%0d wd=%h rdy=%0b wl=%0d err=%0b en=%0b cs=%h want 0/0/0/1/0/0/0/0",
               imem_we, imem_addr, imem_wd, in_ready, words_loaded, error, cpu_enable, checksum); end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_instr(1'b0);
      in_valid = 1'b0;
      v2 = 1'b1;
      w = cur_word();
      tick();
      if (i < 4) begin
        checks++; if (we2 !== 1'b1 || addr2 !== 2'(i) || wd2 !== w || wl2 !== 3'(i + 1)) begin errors++;
          $display("FAIL ovf_write_%0d got we=%0b addr=%0d wd=%h wl=%0d want 1/%0d/%h/%0d", i, we2, addr2, wd2, wl2, i, w, i + 1); end
        checks++; if (err2 !== (i == 3) || rdy2 !== (i != 3)) begin errors++;
          $display("FAIL ovf_state_%0d got err=%0b rdy=%0b want %0b/%0b", i, err2, rdy2, i == 3, i != 3); end
      end else begin
        checks++; if (we2 !== 1'b0 || wl2 !== 3'd4 || err2 !== 1'b1) begin errors++;
          $display("FAIL ovf_fifth got we=%0b wl=%0d err=%0b want 0/4/1", we2, wl2, err2); end
      end
    end
    v2 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_plan_program();
    test_shift_jump();
    test_illegal();
    test_random();
    test_reset_mid_write();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction assembler/loader for the single-cycle MIPS core. It accepts symbolic instructions (mnemonic code plus operand fields), encodes them into 32-bit MIPS machine words, and writes them sequentially into instruction memory. It holds the processor disabled until loading completes, then releases it. It is the encoding counterpart of the core's instruction decoder: every op/func pair that decoder recognises can be produced here.

## Interface
- `AWIDTH`, default 10: instruction-memory word-address width.
- `BASE`, default 0: first word address written.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: instruction request valid.
- `in_ready` out 1: loader can accept a request.
- `in_mnem` in 5: mnemonic code (see Operation).
- `in_rs`, `in_rt`, `in_rd`, `in_shamt` in 5 each: register and shift fields.
- `in_imm` in 16: I-type immediate.
- `in_target` in 26: J-type target.
- `in_last` in 1: marks the final instruction of the program.
- `restart` in 1: return to loading from RUN or ERR.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out AWIDTH: word address.
- `imem_wd` out 32: encoded word.
- `cpu_enable` out 1: drives the core's `enable`.
- `words_loaded` out AWIDTH+1: count of words written.
- `error` out 1: sticky fault flag.
- `checksum` out 32: see Configuration.

## Operation
- Mnemonic codes and encodings (op/func in binary):
  - 0–13 are R-type with op 000000 and func: ADD 100000, ADDU 100001, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SLLV 000100, SRL 000010, SRA 000011, JR 001000.
  - 14 LW 100011, 15 SW 101011, 16 ADDI 001000, 17 ADDIU 001001, 18 SLTI 001010, 19 SLTIU 001011, 20 ORI 001101, 21 LUI 001111, 22 ANDI 001100, 23 XORI 001110, 24 BEQ 000100, 25 BNE 000101, 26 J 000010, 27 JAL 000011.
  - 28–31 are illegal.
- Field rules:
  - R-type ALU: {op, rs, rt, rd, 00000, func}.
  - SLL/SRL/SRA: rs field forced 0, shamt = `in_shamt`.
  - SLLV: {rs, rt, rd}, shamt 0.
  - JR: rt, rd and shamt forced 0.
  - I-type: {op, rs, rt, imm}; LUI forces rs = 0.
  - J/JAL: {op, target}.
  - Unused input fields are ignored.
- FSM states are LOAD, FLUSH, RUN and ERR. Reset enters LOAD.
- LOAD: `in_ready`=1. On accept (`in_valid & in_ready`):
  - Legal mnemonic: the word is written at the current address and the address increments.
  - Legal mnemonic with `in_last`: go to FLUSH.
  - Legal, non-last word accepted at address 2^AWIDTH−1: the word is written, then go to ERR (overflow).
  - Illegal mnemonic: nothing is written; go to ERR.
- FLUSH: lasts one cycle, then go to RUN.
- RUN: `cpu_enable`=1, `in_ready`=0. `restart` moves to LOAD.
- ERR: `error`=1, `in_ready`=0, `cpu_enable`=0. `restart` moves to LOAD and clears `error`.
- Entering LOAD through `restart`: address returns to BASE, `words_loaded` returns to 0, checksum returns to 0.
- `in_valid` without `in_ready` is ignored.

## Timing
- Reset values:
  - `in_ready`=1 (the FSM is in LOAD).
  - `imem_we`=0, `imem_addr`=BASE, `imem_wd`=0.
  - `cpu_enable`=0, `error`=0.
  - `words_loaded`=0, `checksum`=0.
- Write latency is 1 cycle. An accept at edge N registers `imem_we`=1, `imem_addr`, `imem_wd` for the cycle following edge N. `imem_we` is a single-cycle pulse per word.
- Back-to-back accepts produce back-to-back writes at consecutive addresses (throughput 1/cycle).
- `words_loaded` updates at the same edge that drives the write.
- If the last word is accepted at edge N:
  - The write occurs in the cycle after edge N, with the FSM in FLUSH.
  - `cpu_enable` rises at edge N+2, so the core never runs during a write.
- Overflow or illegal-mnemonic entry into ERR is registered at the accept edge; `in_ready` falls at that same edge.
- `reset` overrides everything, including mid-write: the pending write is dropped.
- `restart` in LOAD or FLUSH is ignored.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - `checksum` is the XOR of every word written since reset or restart.
  - It updates at the write edge.
- Undefined: `checksum` is tied to 0 and no checksum register is built.

## Test plan
- ADDI rs=0 rt=8 imm=5, then ADD rs=8 rt=9 rd=10 with last:
  - Writes 0x20080005 at addr 0, then 0x01095020 at addr 1 on consecutive cycles.
  - `cpu_enable` rises 2 edges after the last accept; `words_loaded`=2.
- SLL rt=3 rd=2 shamt=4 with rs=31 supplied, then J target=0x10, then JAL target=0x10 last:
  - Writes 0x00031100, then 0x08000010, then 0x0C000010.
- `in_mnem`=29 after 3 legal words:
  - No write occurs; `error`=1; `in_ready`=0 the next cycle; `words_loaded`=3.
  - `restart` returns to LOAD, `imem_addr`=BASE, `error`=0.
- AWIDTH=2, 5 non-last words offered:
  - 4 writes at addresses 0–3, then ERR; the 5th word is not accepted.
- `reset` asserted in the cycle of a pending write:
  - `imem_we`=0 next cycle; all outputs return to reset values.
- With `IMEM_LOADER_CHECKSUM_EN`, after loading 0x20080005 and 0x01095020:
  - `checksum`=0x21015025. Without the macro, `checksum`=0.
